hazard_ctrl: RTL

- Pipeline hazard and stall controller for the 5-stage RV32 pipeline.
- The forwarding unit resolves ALU data dependences by picking already-produced results. This block covers the cases forwarding cannot resolve: load-use stalls, taken-branch flushes, and data-memory wait freezes with timeout.
- It drives the PC/IF_ID write enables and the flush/freeze controls of the pipeline registers.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_perf_cnt.sv | 37 +++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int                REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
// ============================================================================
// Module      : hazard_perf_cnt
// Description : 32-bit saturating event counter with enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use stall, branch flush and data-memory freeze/timeout
//               control for the 5-stage RV32 pipeline.
//               Optional macro HAZARD_PERF_EN adds hazard performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] IF_ID_rs1,
    input  logic [REG_AW-1:0] IF_ID_rs2,
    input  logic              IF_ID_use_rs1,
    input  logic              IF_ID_use_rs2,
    input  logic [REG_AW-1:0] ID_EX_rd,
    input  logic              ID_EX_MemRead,
    input  logic              branch_taken,
    input  logic              EX_MEM_MemAccess,
    input  logic              dmem_ready,
    output logic              PC_write,
    output logic              IF_ID_write,
    output logic              IF_ID_flush,
    output logic              ID_EX_flush,
    output logic              pipe_freeze,
    output logic              mem_timeout
`ifdef HAZARD_PERF_EN
   ,output logic [31:0]       perf_loaduse_cnt,
    output logic [31:0]       perf_flush_cnt,
    output logic [31:0]       perf_freeze_cnt
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic w_freeze;
    logic w_loaduse;

    assign w_freeze  = EX_MEM_MemAccess && !dmem_ready && (state_q != ERROR);
    assign w_loaduse = ID_EX_MemRead && (ID_EX_rd != REG_X0) &&
                       ((IF_ID_use_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                        (IF_ID_use_rs2 && (IF_ID_rs2 == ID_EX_rd)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (w_freeze) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!w_freeze) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                    state_d       = ERROR;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ERROR: begin
                mem_timeout_d = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Priority: reset > error > memory freeze > branch flush > load-use stall.
    always_comb begin
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        pipe_freeze = 1'b0;
        if (!rst_n) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if ((state_q == ERROR) || w_freeze) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_freeze = 1'b1;
        end else if (branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (w_loaduse) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end
    end

    assign mem_timeout = mem_timeout_q && rst_n;

`ifdef HAZARD_PERF_EN
    logic w_act_freeze;
    logic w_act_flush;
    logic w_act_loaduse;

    assign w_act_freeze  = rst_n && w_freeze;
    assign w_act_flush   = rst_n && (state_q != ERROR) && !w_freeze && branch_taken;
    assign w_act_loaduse = rst_n && (state_q != ERROR) && !w_freeze && !branch_taken && w_loaduse;

    hazard_perf_cnt u_perf_loaduse (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (w_act_loaduse),
        .cnt_o (perf_loaduse_cnt)
    );

    hazard_perf_cnt u_perf_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (w_act_flush),
        .cnt_o (perf_flush_cnt)
    );

    hazard_perf_cnt u_perf_freeze (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (w_act_freeze),
        .cnt_o (perf_freeze_cnt)
    );
`endif

endmodule

`default_nettype wire
